// File: rtl/simt_pc_unit.sv
// Per-block PC sequencer and divergence controller that sits beside the SIMT stack.
// Optional build macro: SIMT_PC_DIVERGE_CHECK_EN (uniform-branch checking plus the diverge_err output).
module simt_pc_unit #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [3:0]                       core_state,
  input  logic                             start,
  input  logic [THREADS_PER_BLOCK-1:0]     launch_mask,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             decoded_pc_mux,
  input  logic                             decoded_ssy,
  input  logic                             decoded_sync,
  input  logic                             decoded_ret,
  input  logic [2:0]                       decoded_nzp,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] decoded_immediate,
  input  logic [3*THREADS_PER_BLOCK-1:0]   nzp,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] branch_pc,
  input  logic [1:0]                       remain_route,
  output logic [THREADS_PER_BLOCK-1:0]     current_mask,
  output logic [THREADS_PER_BLOCK-1:0]     origin_mask,
  output logic [THREADS_PER_BLOCK-1:0]     active_mask,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic                             done,
  output logic [1:0]                       fsm_state
`ifdef SIMT_PC_DIVERGE_CHECK_EN
  ,
  output logic                             diverge_err
`endif
);

  localparam int N = PROGRAM_MEM_ADDR_BITS;
  localparam int T = THREADS_PER_BLOCK;
  localparam logic [3:0] CORE_IDLE    = 4'b0000;
  localparam logic [3:0] CORE_EXECUTE = 4'b0110;
  localparam logic [N-1:0] PC_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    CONV   = 2'd0,
    PATH_A = 2'd1,
    PATH_B = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [T-1:0]   taken;
  logic [N-1:0]   pc_inc;
  logic           exec;
  logic           launch;
  logic           br_take;

  assign exec      = enable && (core_state == CORE_EXECUTE);
  assign launch    = (core_state == CORE_IDLE) && start;
  assign pc_inc    = current_pc + PC_ONE;
  assign fsm_state = state;

  // Thread match against the branch condition, restricted to the threads running now.
  always_comb begin
    current_mask = '0;
    for (int i = 0; i < T; i++) begin
      current_mask[i] = (|(nzp[3*i +: 3] & decoded_nzp)) & active_mask[i];
    end
  end

`ifdef SIMT_PC_DIVERGE_CHECK_EN
  assign br_take = (current_mask == active_mask);
`else
  assign br_take = |current_mask;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CONV;
    end else if (launch) begin
      state <= CONV;
    end else begin
      state <= state_next;
    end
  end

  // An SSY with no matching thread jumps straight to the second path.
  always_comb begin
    state_next = state;
    if (exec) begin
      if (decoded_ssy) begin
        state_next = (|current_mask) ? PATH_A : PATH_B;
      end else if (decoded_sync) begin
        state_next = (remain_route == 2'd2) ? PATH_B : CONV;
      end
    end
  end

  always_comb begin
    active_mask = origin_mask;
    case (state)
      PATH_A:  active_mask = origin_mask & taken;
      PATH_B:  active_mask = origin_mask & ~taken;
      default: active_mask = origin_mask;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc     <= '0;
      origin_mask <= '1;
      taken       <= '0;
      done        <= 1'b0;
    end else if (launch) begin
      next_pc     <= '0;
      origin_mask <= launch_mask;
      taken       <= '0;
      done        <= 1'b0;
    end else if (exec) begin
      if (decoded_ssy) begin
        taken   <= current_mask;
        next_pc <= (|current_mask) ? pc_inc : decoded_immediate;
      end else if (decoded_sync) begin
        next_pc <= (remain_route == 2'd2) ? branch_pc : pc_inc;
      end else if (decoded_pc_mux) begin
        next_pc <= br_take ? decoded_immediate : pc_inc;
      end else if (decoded_ret) begin
        done    <= 1'b1;
        next_pc <= current_pc;
      end else begin
        next_pc <= pc_inc;
      end
    end
  end

`ifdef SIMT_PC_DIVERGE_CHECK_EN
  logic err_set;

  // Flag non-uniform branches, nested SSY and RET while paths are still split.
  always_comb begin
    err_set = 1'b0;
    if (decoded_ssy) begin
      err_set = (state != CONV);
    end else if (decoded_sync) begin
      err_set = 1'b0;
    end else if (decoded_pc_mux) begin
      err_set = (|current_mask) && (current_mask != active_mask);
    end else if (decoded_ret) begin
      err_set = (state != CONV);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      diverge_err <= 1'b0;
    end else if (launch) begin
      diverge_err <= 1'b0;
    end else if (exec && err_set) begin
      diverge_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_simt_pc_unit.sv
// Scoreboard bench for simt_pc_unit: directed scenarios followed by random instruction streams.
module tb_simt_pc_unit;
  localparam int N = 8;
  localparam int T = 4;
  localparam int W = 26;
  localparam logic [3:0] CORE_IDLE    = 4'b0000;
  localparam logic [3:0] CORE_EXECUTE = 4'b0110;
`ifdef SIMT_PC_DIVERGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [3:0]     core_state = CORE_IDLE;
  logic           start = 1'b0;
  logic [T-1:0]   launch_mask = '1;
  logic [N-1:0]   current_pc = '0;
  logic           decoded_pc_mux = 1'b0;
  logic           decoded_ssy = 1'b0;
  logic           decoded_sync = 1'b0;
  logic           decoded_ret = 1'b0;
  logic [2:0]     decoded_nzp = '0;
  logic [N-1:0]   decoded_immediate = '0;
  logic [3*T-1:0] nzp = '0;
  logic [N-1:0]   branch_pc = '0;
  logic [1:0]     remain_route = '0;
  logic [T-1:0]   current_mask;
  logic [T-1:0]   origin_mask;
  logic [T-1:0]   active_mask;
  logic [N-1:0]   next_pc;
  logic           done;
  logic [1:0]     fsm_state;
  logic           dut_err;

  simt_pc_unit #(.PROGRAM_MEM_ADDR_BITS(N), .THREADS_PER_BLOCK(T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state), .start(start),
    .launch_mask(launch_mask), .current_pc(current_pc), .decoded_pc_mux(decoded_pc_mux),
    .decoded_ssy(decoded_ssy), .decoded_sync(decoded_sync), .decoded_ret(decoded_ret),
    .decoded_nzp(decoded_nzp), .decoded_immediate(decoded_immediate), .nzp(nzp),
    .branch_pc(branch_pc), .remain_route(remain_route), .current_mask(current_mask),
    .origin_mask(origin_mask), .active_mask(active_mask), .next_pc(next_pc), .done(done),
    .fsm_state(fsm_state)
`ifdef SIMT_PC_DIVERGE_CHECK_EN
    , .diverge_err(dut_err)
`endif
  );
`ifndef SIMT_PC_DIVERGE_CHECK_EN
  assign dut_err = 1'b0;
`endif

  // reference model: which path runs (0 none split, 1 first, 2 second) and launch/taken thread sets
  logic [N-1:0] m_pc;
  logic         m_done;
  logic [T-1:0] m_origin;
  logic [T-1:0] m_taken;
  int           m_path;
  logic         m_err;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [T-1:0] model_active();
    if (m_path == 1) return m_origin & m_taken;
    if (m_path == 2) return m_origin & ~m_taken;
    return m_origin;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_done = 1'b0; m_origin = '1; m_taken = '0; m_path = 0; m_err = 1'b0;
  endtask

  // Advance the model by one clock with the currently driven inputs and queue the expectation.
  task automatic tick();
    logic [T-1:0] act, cur;
    logic [N-1:0] pc1;
    bit take;
    act = model_active();
    cur = '0;
    for (int i = 0; i < T; i++)
      if (((nzp[3*i +: 3] & decoded_nzp) != 3'b000) && act[i]) cur[i] = 1'b1;
    pc1 = N'((int'(current_pc) + 1) % (1 << N));
    if (reset) begin
      model_reset();
    end else if (core_state == CORE_IDLE && start) begin
      m_origin = launch_mask; m_pc = '0; m_done = 1'b0; m_taken = '0; m_path = 0; m_err = 1'b0;
    end else if (core_state == CORE_EXECUTE && enable) begin
      if (decoded_ssy) begin
        if (CHK && m_path != 0) m_err = 1'b1;
        m_taken = cur;
        if (cur != 0) begin m_path = 1; m_pc = pc1; end
        else begin m_path = 2; m_pc = decoded_immediate; end
      end else if (decoded_sync) begin
        if (remain_route == 2) begin m_path = 2; m_pc = branch_pc; end
        else begin m_path = 0; m_pc = pc1; end
      end else if (decoded_pc_mux) begin
        take = CHK ? (cur == act) : (cur != 0);
        if (CHK && cur != 0 && cur != act) m_err = 1'b1;
        m_pc = take ? decoded_immediate : pc1;
      end else if (decoded_ret) begin
        if (CHK && m_path != 0) m_err = 1'b1;
        m_done = 1'b1;
        m_pc = current_pc;
      end else begin
        m_pc = pc1;
      end
    end
    exp_q.push_back({cur, act, m_pc, m_done, m_origin, model_active(), m_err});
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor: combinational outputs mid-cycle, registered outputs just after the edge
  initial begin
    logic [W-1:0] rec;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        chk("current_mask", 32'(current_mask), 32'(rec[25:22]));
        chk("active_mask_pre", 32'(active_mask), 32'(rec[21:18]));
        @(posedge clk);
        #1;
        chk("next_pc", 32'(next_pc), 32'(rec[17:10]));
        chk("done", 32'(done), 32'(rec[9]));
        chk("origin_mask", 32'(origin_mask), 32'(rec[8:5]));
        chk("active_mask_post", 32'(active_mask), 32'(rec[4:1]));
        if (CHK) chk("diverge_err", 32'(dut_err), 32'(rec[0]));
      end
    end
  end

  // driver tasks; op bits are {ssy, sync, brnzp, ret}
  task automatic exec_op(input logic [3:0] op, input logic [N-1:0] pc, input logic [2:0] dn,
                         input logic [N-1:0] imm);
    reset = 1'b0; enable = 1'b1; core_state = CORE_EXECUTE; start = 1'b0;
    {decoded_ssy, decoded_sync, decoded_pc_mux, decoded_ret} = op;
    current_pc = pc; decoded_nzp = dn; decoded_immediate = imm;
    tick();
  endtask

  task automatic set_threads(input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2,
                             input logic [2:0] t3);
    nzp = {t3, t2, t1, t0};
  endtask

  task automatic launch_block(input logic [T-1:0] lm);
    reset = 1'b0; enable = 1'b1; core_state = CORE_IDLE; start = 1'b1; launch_mask = lm;
    {decoded_ssy, decoded_sync, decoded_pc_mux, decoded_ret} = 4'b0000;
    tick();
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // 1: reset state, then reset held mid-divergence
    repeat (2) tick();
    set_threads(3'b010, 3'b010, 3'b100, 3'b100);
    exec_op(4'b0000, 8'd0, 3'b000, 8'd0);
    exec_op(4'b1000, 8'd5, 3'b010, 8'd12);
    reset = 1'b1;
    exec_op(4'b0000, 8'd6, 3'b000, 8'd0);
    reset = 1'b1; tick(); tick();
    // 2: two-sided divergence and reconvergence
    exec_op(4'b1000, 8'd5, 3'b010, 8'd12);
    exec_op(4'b0000, 8'd6, 3'b010, 8'd0);
    branch_pc = 8'd12; remain_route = 2'd2;
    exec_op(4'b0100, 8'd10, 3'b000, 8'd0);
    remain_route = 2'd1;
    exec_op(4'b0100, 8'd15, 3'b000, 8'd0);
    // 3: SSY with no matching thread skips the empty path
    exec_op(4'b1000, 8'd5, 3'b001, 8'd12);
    exec_op(4'b0100, 8'd15, 3'b000, 8'd0);
    // 4: branches: all, none, partial match
    set_threads(3'b010, 3'b010, 3'b010, 3'b010);
    exec_op(4'b0010, 8'd7, 3'b010, 8'd20);
    exec_op(4'b0010, 8'd20, 3'b001, 8'd20);
    set_threads(3'b010, 3'b010, 3'b100, 3'b100);
    exec_op(4'b0010, 8'd21, 3'b010, 8'd20);
    // 5: PC wrap, then no update outside EXECUTE or when disabled
    exec_op(4'b0000, 8'd255, 3'b000, 8'd0);
    core_state = CORE_IDLE; current_pc = 8'd40; tick();
    core_state = 4'b0011; tick();
    core_state = CORE_EXECUTE; enable = 1'b0; tick();
    // 6: RET is sticky until a new launch
    exec_op(4'b0001, 8'd30, 3'b000, 8'd0);
    exec_op(4'b0000, 8'd31, 3'b000, 8'd0);
    launch_block(4'b0101);
    exec_op(4'b0000, 8'd0, 3'b111, 8'd0);
    // priority with several decode flags together
    exec_op(4'b1111, 8'd50, 3'b010, 8'd60);
    exec_op(4'b0111, 8'd51, 3'b010, 8'd60);
    exec_op(4'b0011, 8'd52, 3'b010, 8'd60);
    launch_block(4'b1111);
    // random instruction streams
    for (int n = 0; n < 400; n++) begin
      nzp = 12'($urandom_range(0, 4095));
      branch_pc = 8'($urandom_range(0, 255));
      remain_route = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        launch_block(4'($urandom_range(0, 15)));
      end else begin
        exec_op(4'($urandom_range(0, 15) & ($urandom_range(0, 1) ? 4'b0000 : 4'b1111)),
                8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        enable = ($urandom_range(0, 9) != 0);
        core_state = ($urandom_range(0, 9) != 0) ? CORE_EXECUTE : 4'($urandom_range(0, 15));
        if (!enable || core_state != CORE_EXECUTE) tick();
      end
    end
    {decoded_ssy, decoded_sync, decoded_pc_mux, decoded_ret} = 4'b0000;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
